// File: rtl/regfile_param.sv
// regfile_param: parametrised integer register file with a post-reset
// clear sweep and a sticky halt. Optional macro: REGFILE_BYPASS_EN.
module regfile_param #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   parameter  int NREAD = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  finish_flag,
   input  logic                  RegWrite,
   input  logic [AW-1:0]         RD,
   input  logic [XLEN-1:0]       WriteData,
   input  logic [NREAD*AW-1:0]   ReadAddr,
   output logic [NREAD*XLEN-1:0] ReadData,
   output logic                  ready,
   output logic                  halted,
   output logic [31:0]           wr_count
);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_HALT
   } state_e;

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   state_e            state_q, state_d;
   logic [AW-1:0]     ptr_q, ptr_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic              halted_q, halted_d;
   logic [XLEN-1:0]   rf_q [NREGS];

   logic              commit;
   logic              clr;

   // A write commits only in RUN, when finish is not pending and rd is not x0
   assign commit = (state_q == ST_RUN) && !finish_flag
                && RegWrite && (RD != '0);
   assign clr    = (state_q == ST_INIT);

   // Next-state logic for the sweep / run / halt sequencer
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_INIT: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == LAST) begin
               state_d = ST_RUN;
               ptr_d   = '0;
            end
         end
         ST_RUN: begin
            if (finish_flag) begin
               state_d = ST_HALT;
            end else if (commit) begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_INIT;
            ptr_d   = '0;
         end
      endcase
      ready_d  = (state_d == ST_RUN);
      halted_d = (state_d == ST_HALT);
   end

   // Sequencer state and registered status outputs; reset wins over all
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_INIT;
         ptr_q    <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         halted_q <= halted_d;
      end
   end

   // Storage: sweep clears one entry per edge, RUN commits one write
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (clr) begin
            rf_q[ptr_q] <= '0;
         end else if (commit) begin
            rf_q[RD] <= WriteData;
         end
      end
   end

   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;

      assign addr = ReadAddr[g*AW +: AW];

      // Read port: zero in INIT and for x0, optional write-through forward
      always_comb begin
         data = '0;
         if (!clr && (addr != '0)) begin
            data = rf_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (commit && (addr == RD)) begin
               data = WriteData;
            end
`endif
         end
      end

      assign ReadData[g*XLEN +: XLEN] = data;
   end

   assign ready    = ready_q;
   assign halted   = halted_q;
   assign wr_count = cnt_q;

endmodule
